// File: rtl/regdump_scanner_pkg.sv
// regdump_scanner_pkg: shared types, defaults and helpers for the register-dump scanner.
// Revision 1.0
`default_nettype none

package regdump_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SEND_A = 2'd2,
    ST_SEND_B = 2'd3
  } state_e;

  localparam int NREG_DEFAULT = 32;
  localparam int DW_DEFAULT   = 32;
  localparam int AW_DEFAULT   = 5;

  // The register file is only safe to walk while both read ports are open and loads are blocked.
  function automatic logic is_frozen(input logic a_en, input logic b_en, input logic ld_en);
    return a_en & b_en & ~ld_en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regdump_scanner_out_reg.sv
// regdump_scanner_out_reg: registered valid/ready output stage with stall-hold of data and index.
// Revision 1.0
`default_nettype none

module regdump_scanner_out_reg #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] load_idx,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid
);

  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;

  // A load in the same cycle as an accept replaces the word, so back-to-back words need no bubble.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = load_data;
      idx_d   = load_idx;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/regdump_scanner.sv
// regdump_scanner: walks a frozen register file pairwise (A=even, B=odd) and streams each word out.
// Revision 1.0
`default_nettype none

module regdump_scanner
  import regdump_scanner_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          a_en,
  input  logic          b_en,
  input  logic          ld_en,
  output logic [AW-1:0] ra_addr,
  output logic [AW-1:0] rb_addr,
  input  logic [DW-1:0] rd_a,
  input  logic [DW-1:0] rd_b,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam int             P_W    = AW - 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(NREG / 2 - 1);

  state_e         state_q, state_d;
  logic [P_W-1:0] p_q, p_d;
  logic [DW-1:0]  b_h_q, b_h_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           abort_q, abort_d;

  logic           frozen;
  logic           hs;
  logic           ld;
  logic           clr;
  logic [DW-1:0]  ld_data;
  logic [AW-1:0]  ld_idx;

  assign frozen  = is_frozen(a_en, b_en, ld_en);
  assign hs      = out_valid & out_ready;
  assign ra_addr = {p_q, 1'b0};
  assign rb_addr = {p_q, 1'b1};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_h_d   = b_h_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    ld      = 1'b0;
    clr     = 1'b0;
    ld_data = '0;
    ld_idx  = '0;
    // Losing the freeze cancels the walk outright; the partially sent pair is not resumed.
    if (state_q != ST_IDLE && !frozen) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      abort_d = 1'b1;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && frozen) begin
            state_d = ST_READ;
            busy_d  = 1'b1;
            p_d     = '0;
          end
        end
        ST_READ: begin
          b_h_d   = rd_b;
          ld      = 1'b1;
          ld_data = rd_a;
          ld_idx  = {p_q, 1'b0};
          state_d = ST_SEND_A;
        end
        ST_SEND_A: begin
          if (hs) begin
            ld      = 1'b1;
            ld_data = b_h_q;
            ld_idx  = {p_q, 1'b1};
            state_d = ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (hs) begin
            if (p_q == P_LAST) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              p_d     = p_q + P_W'(1);
              state_d = ST_READ;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      b_h_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_h_q   <= b_h_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign abort = abort_q;

  regdump_scanner_out_reg #(
    .AW (AW),
    .DW (DW)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .clear     (clr),
    .load_data (ld_data),
    .load_idx  (ld_idx),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_regdump_scanner.sv
// tb_regdump_scanner: directed self-checking bench for regdump_scanner (NREG=32, AW=5, DW=32).
// Revision 1.0
`default_nettype none

module tb_regdump_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic        a_en;
  logic        b_en;
  logic        ld_en;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        abort;

  int n_tests = 0;
  int n_fail  = 0;

  // Register file model: r[i] = i * 0x01010101
  assign rd_a = {27'd0, ra_addr} * 32'h01010101;
  assign rd_b = {27'd0, rb_addr} * 32'h01010101;

  regdump_scanner #(
    .NREG (32),
    .AW   (5),
    .DW   (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_en      (a_en),
    .b_en      (b_en),
    .ld_en     (ld_en),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_en = 1'b1; b_en = 1'b1; ld_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ra_addr !== 5'd0) begin n_fail++; $display("FAIL reset_ra_addr: got %0d want 0", ra_addr); end
    n_tests++; if (rb_addr !== 5'd1) begin n_fail++; $display("FAIL reset_rb_addr: got %0d want 1", rb_addr); end
    n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_tests++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    n_tests++; if ({out_valid, busy, done, abort} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got valid/busy/done/abort=%b want 0000", {out_valid, busy, done, abort});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: got valid/busy=%b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_full_dump();
    int exp_idx = 0;
    int dones = 0;
    int done_k = 0;
    int first_k = 0;
    logic [31:0] exp_d;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && first_k == 0) first_k = k;
      if (done) begin dones++; done_k = k; end
      if (out_valid && out_ready) begin
        exp_d = 32'h01010101 * 32'(exp_idx);
        n_tests++; if (out_idx !== 5'(exp_idx)) begin n_fail++; $display("FAIL full_idx: got %0d want %0d", out_idx, exp_idx); end
        n_tests++; if (out_data !== exp_d) begin n_fail++; $display("FAIL full_data: got %h want %h", out_data, exp_d); end
        n_tests++;
        if ((exp_idx % 2 == 0) ? (ra_addr !== 5'(exp_idx)) : (rb_addr !== 5'(exp_idx))) begin
          n_fail++; $display("FAIL full_addr: ra=%0d rb=%0d want idx %0d on its port", ra_addr, rb_addr, exp_idx);
        end
        exp_idx++;
      end
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_tests++; if (first_k != 2) begin n_fail++; $display("FAIL full_first_valid: got cycle %0d want 2", first_k); end
    n_tests++; if (done_k != 49) begin n_fail++; $display("FAIL full_total_cycles: got %0d want 49", done_k); end
    n_tests++; if (exp_idx != 32) begin n_fail++; $display("FAIL full_word_count: got %0d want 32", exp_idx); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", dones); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    logic [15:0] pat;
    logic        stalled;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    logic [31:0] exp_d;
    int exp_idx = 0;
    int dones = 0;
    pat = 16'b1001_0110_0011_1001;
    stalled = 1'b0; held_d = '0; held_i = '0;
    start = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 600 && dones == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_idx !== held_i) begin
          n_fail++; $display("FAIL stall_hold: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", out_valid, out_data, out_idx, held_d, held_i);
        end
      end
      if (done) dones++;
      out_ready = pat[k % 16];
      if (out_valid && out_ready) begin
        exp_d = 32'h01010101 * 32'(exp_idx);
        n_tests++; if (out_idx !== 5'(exp_idx) || out_data !== exp_d) begin
          n_fail++; $display("FAIL stall_word: got i=%0d d=%h want i=%0d d=%h", out_idx, out_data, exp_idx, exp_d);
        end
        exp_idx++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1; held_d = out_data; held_i = out_idx;
      end else begin
        stalled = 1'b0;
      end
    end
    out_ready = 1'b1;
    n_tests++; if (exp_idx != 32) begin n_fail++; $display("FAIL stall_word_count: got %0d want 32", exp_idx); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_not_frozen();
    ld_en = 1'b1; start = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      n_tests++; if ({busy, out_valid} !== 2'b00) begin
        n_fail++; $display("FAIL unfrozen_start: got busy/valid=%b want 00", {busy, out_valid});
      end
    end
    start = 1'b0; ld_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int exp_idx = 0;
    int dones = 0;
    bit aborted = 1'b0;
    logic [31:0] exp_d;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 100 && !aborted; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_ready) begin
        n_tests++; if (out_idx !== 5'(exp_idx)) begin n_fail++; $display("FAIL abort_pre_idx: got %0d want %0d", out_idx, exp_idx); end
        if (exp_idx == 9) begin ld_en = 1'b1; aborted = 1'b1; end
        exp_idx++;
      end
    end
    n_tests++; if (!aborted) begin n_fail++; $display("FAIL abort_reach_idx9: got %0d words want 10", exp_idx); end
    @(posedge clk); #1;
    n_tests++; if ({abort, out_valid, busy, done} !== 4'b1000) begin
      n_fail++; $display("FAIL abort_pulse: got abort/valid/busy/done=%b want 1000", {abort, out_valid, busy, done});
    end
    @(posedge clk); #1;
    n_tests++; if ({abort, out_valid, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_after: got abort/valid/busy/done=%b want 0000", {abort, out_valid, busy, done});
    end
    ld_en = 1'b0;
    @(posedge clk); #1;
    exp_idx = 0;
    start = 1'b1;
    for (int k = 1; k <= 200 && dones == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
      if (out_valid && out_ready) begin
        exp_d = 32'h01010101 * 32'(exp_idx);
        n_tests++; if (out_idx !== 5'(exp_idx) || out_data !== exp_d) begin
          n_fail++; $display("FAIL abort_restart_word: got i=%0d d=%h want i=%0d d=%h", out_idx, out_data, exp_idx, exp_d);
        end
        exp_idx++;
      end
    end
    n_tests++; if (exp_idx != 32 || dones != 1) begin
      n_fail++; $display("FAIL abort_restart_total: got %0d words %0d done want 32 words 1 done", exp_idx, dones);
    end
  endtask

  task automatic test_rst_mid();
    bit hit = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 100 && !hit; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_idx == 5'd11) begin rst = 1'b1; hit = 1'b1; end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach: got no idx 11 want idx 11 presented"); end
    @(posedge clk); #1;
    n_tests++; if (ra_addr !== 5'd0 || rb_addr !== 5'd1 || out_data !== 32'd0 || out_idx !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_values: got ra=%0d rb=%0d d=%h i=%0d want 0 1 0 0", ra_addr, rb_addr, out_data, out_idx);
    end
    n_tests++; if ({out_valid, busy, done, abort} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_flags: got valid/busy/done/abort=%b want 0000", {out_valid, busy, done, abort});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({out_valid, busy, done, abort} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_release: got valid/busy/done/abort=%b want 0000", {out_valid, busy, done, abort});
    end
  endtask

  task automatic test_back_to_back();
    int exp_idx = 0;
    int dones = 0;
    int extra = 0;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 200 && dones == 0; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start = (dones == 0) && (k % 3 != 2);
      if (out_valid && out_ready) begin
        n_tests++; if (out_idx !== 5'(exp_idx)) begin n_fail++; $display("FAIL retrig_idx: got %0d want %0d", out_idx, exp_idx); end
        exp_idx++;
      end
    end
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid || busy || done) extra++;
    end
    n_tests++; if (exp_idx != 32) begin n_fail++; $display("FAIL retrig_word_count: got %0d want 32", exp_idx); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL retrig_done_count: got %0d want 1", dones); end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL retrig_restart: got %0d active cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_not_frozen();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion want completion within 1ms");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/regdump_scanner.md
Name: regdump_scanner

Overview:
- Debug-side consumer of the register-file debug controls (a-read enable, b-read enable, load enable).
- While debug mode holds the register file frozen (reads enabled, load disabled), it walks every register through read ports A and B. Port A reads even indices, port B reads odd indices.
- Each word is streamed out one at a time over a valid/ready handshake to the debug host link.
- Sits between the debug control block, the register-file read ports and the debug output channel.

Parameters:
- NREG, 32, number of registers to dump; must be even and at least 2.
- AW, 5, register address width; 2**AW >= NREG.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse or level; begins a dump when the block is IDLE and the register file is frozen.
- a_en  input  1  register-file port A read enable from the debug control.
- b_en  input  1  register-file port B read enable from the debug control.
- ld_en  input  1  register-file write/load enable; 0 means the file is frozen.
- ra_addr  output  AW  port A read address (even index).
- rb_addr  output  AW  port B read address (odd index).
- rd_a  input  DW  port A read data, combinational from ra_addr.
- rd_b  input  DW  port B read data, combinational from rb_addr.
- out_data  output  DW  dumped register value.
- out_idx  output  AW  index of the register in out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse after the last word is accepted.
- abort  output  1  one-cycle pulse when a dump is cancelled by unfreeze.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, pair counter 0, ra_addr=0, rb_addr=1, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, abort=0.
- frozen = a_en & b_en & ~ld_en.
- IDLE:
  - on start & frozen go to READ, busy=1, pair counter p=0.
  - start without frozen is ignored.
- READ (1 cycle):
  - ra_addr=2p, rb_addr=2p+1 are already driven; capture rd_a and rd_b into holding registers A_h and B_h.
  - next state SEND_A.
- SEND_A:
  - out_valid=1, out_data=A_h, out_idx=2p.
  - on out_valid & out_ready go to SEND_B.
- SEND_B:
  - out_data=B_h, out_idx=2p+1.
  - on handshake:
    - if p == NREG/2-1, go to IDLE, busy=0, done pulses 1 the next cycle.
    - else p=p+1 and go to READ.
- Outputs are registered. out_data and out_idx hold stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on abort or reset.
- Latency:
  - start to first out_valid = 2 cycles (IDLE→READ→SEND_A).
  - With out_ready held at 1, a pair takes 3 cycles, so a full dump is 3*NREG/2 + 1 cycles.
- Abort:
  - frozen deasserting in any non-IDLE state forces IDLE next cycle.
  - out_valid=0, busy=0, abort pulses 1, done stays 0.
  - A handshake in that same cycle is still counted as accepted.
- Start while busy is ignored; a re-trigger needs a return to IDLE.
- rst mid-dump returns to the reset values immediately; no done or abort pulse.
- Address arithmetic: p is AW-1 bits wide; ra_addr = {p,1'b0}, rb_addr = {p,1'b1}; no wrap past NREG-1.
- Addresses are driven from p in all states (combinational from registers); ra_addr and rb_addr only change on READ entry.

Decomposition:
- Shared package debug_pkg holds:
  - state enum ST_IDLE, ST_READ, ST_SEND_A, ST_SEND_B;
  - constants NREG_DEFAULT=32, DW_DEFAULT=32;
  - a frozen-condition function.
- One natural sub-module: dump_out_reg, the registered valid/ready output stage holding data/idx/valid with stall-hold.

Test Plan:
- Reset, then start with a_en=b_en=1, ld_en=0, regfile model r[i]=i*0x01010101, out_ready=1 → 32 words, idx 0..31 in order, data r[idx]; done pulses exactly once; total 49 cycles from start.
- Same as the first test but out_ready toggles 1,0,0,1 pseudo-randomly → no word lost or duplicated; out_data/out_idx stable during every stall.
- start with ld_en=1 → stays IDLE; busy=0, out_valid=0 for 10 cycles.
- Mid-dump (after idx 9 accepted), ld_en→1 → abort pulses one cycle, out_valid=0 next cycle, no done; a new start after refreeze dumps again from idx 0.
- Assert rst while in SEND_B of pair 5 → next cycle all outputs at reset values, no done or abort pulse.
- start pulsed repeatedly during a dump → ignored; exactly 32 words and one done.
